// File: rtl/fp_pkg.sv
// Shared floating-point datapath types: FSM states, add/sub opcodes, default widths.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MW_DEF = 24;
    localparam int EW_DEF = 8;

endpackage

// File: rtl/sm_magnitude_addsub.sv
// Sign-magnitude add/subtract of two magnitudes, combinational.
// Like signs add; unlike signs give larger minus smaller with the larger's sign.
module sm_magnitude_addsub #(
    parameter int MW = 24
) (
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    input  logic          sign_a,
    input  logic          sb,
    output logic [MW:0]   sum,
    output logic          sign,
    output logic          eq
);

    always_comb begin
        eq   = (a == b);
        sum  = '0;
        sign = sign_a;
        if (sign_a == sb) begin
            sum = {1'b0, a} + {1'b0, b};
        end else if (a >= b) begin
            sum = {1'b0, a} - {1'b0, b};
        end else begin
            sum  = {1'b0, b} - {1'b0, a};
            sign = sb;
        end
    end

endmodule

// File: rtl/sm_addsub_norm.sv
// Sign-magnitude mantissa add/sub with carry fix-up and iterative leading-one normalisation.
// Latency n+2 cycles for n left shifts; no backpressure, start is ignored while busy.
module sm_addsub_norm
    import fp_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic [MW-1:0] mag_a,
    input  logic [MW-1:0] mag_b,
    input  logic [EW-1:0] exp_in,
    output logic          busy,
    output logic          done,
    output logic          sign_s,
    output logic [MW-1:0] mag_s,
    output logic [EW-1:0] exp_s,
    output logic          zero,
    output logic          ovf,
    output logic          unf
);

    state_t        state;
    logic [MW-1:0] a_r, b_r;
    logic          sa_r, sb_r, op_r;
    logic [EW-1:0] exp_r;

    logic          sb_eff;
    logic [MW:0]   sum;
    logic          res_sign;
    logic          eq;
    logic [EW-1:0] exp_inc;

    assign sb_eff  = sb_r ^ (op_r == OP_SUB);
    assign exp_inc = exp_r + EW'(1);

    sm_magnitude_addsub #(.MW(MW)) u_mag (
        .a      (a_r),
        .b      (b_r),
        .sign_a (sa_r),
        .sb     (sb_eff),
        .sum    (sum),
        .sign   (res_sign),
        .eq     (eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sign_s <= 1'b0;
            mag_s  <= '0;
            exp_s  <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            op_r   <= 1'b0;
            exp_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= mag_a;
                        b_r   <= mag_b;
                        sa_r  <= sign_a;
                        sb_r  <= sign_b;
                        op_r  <= op;
                        exp_r <= exp_in;
                        zero  <= 1'b0;
                        ovf   <= 1'b0;
                        unf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (sa_r == sb_eff) begin
                        sign_s <= res_sign;
                        if (sum[MW]) begin
                            // Carry out: renormalise right, dropping the LSB.
                            mag_s <= sum[MW:1];
                            exp_s <= exp_inc;
                            ovf   <= (exp_inc == '1);
                        end else begin
                            mag_s <= sum[MW-1:0];
                            exp_s <= exp_r;
                        end
                    end else if (eq) begin
                        mag_s  <= '0;
                        exp_s  <= '0;
                        sign_s <= 1'b0;
                        zero   <= 1'b1;
                    end else begin
                        mag_s  <= sum[MW-1:0];
                        exp_s  <= exp_r;
                        sign_s <= res_sign;
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (zero || mag_s[MW-1] || ovf) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (exp_s == '0) begin
                        unf   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mag_s <= {mag_s[MW-2:0], 1'b0};
                        exp_s <= exp_s - EW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_addsub_norm.sv
// Directed bench for sm_addsub_norm at MW=24, EW=8 with hand-computed results.
module tb_sm_addsub_norm;

    localparam int MW = 24;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic          sign_a = 1'b0;
    logic          sign_b = 1'b0;
    logic [MW-1:0] mag_a = '0;
    logic [MW-1:0] mag_b = '0;
    logic [EW-1:0] exp_in = '0;
    logic          busy, done, sign_s, zero, ovf, unf;
    logic [MW-1:0] mag_s;
    logic [EW-1:0] exp_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sm_addsub_norm #(.MW(MW), .EW(EW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .exp_in (exp_in),
        .busy   (busy),
        .done   (done),
        .sign_s (sign_s),
        .mag_s  (mag_s),
        .exp_s  (exp_s),
        .zero   (zero),
        .ovf    (ovf),
        .unf    (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one operation and check result, flags, latency and the handshake.
    // A nonnegative glitch_at pulses start with junk operands at that cycle.
    task automatic run_op(input string tag, input logic sa, input logic [MW-1:0] ma,
                          input logic sbv, input logic [MW-1:0] mb, input logic [EW-1:0] e,
                          input logic o, input int glitch_at,
                          input logic [MW-1:0] x_mag, input logic [EW-1:0] x_exp,
                          input logic x_sign, input logic x_z, input logic x_o,
                          input logic x_u, input int x_lat);
        int  lat;
        bit  got;
        @(negedge clk);
        sign_a = sa; mag_a = ma; sign_b = sbv; mag_b = mb; exp_in = e; op = o;
        start = 1'b1;
        @(posedge clk);
        got = 0;
        lat = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            start = (i == glitch_at);
            if (i == glitch_at) begin
                mag_a = 24'h123456; mag_b = 24'h000001; exp_in = 8'h33;
            end
            if (i == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                got = 1;
                lat = i;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(x_lat));
        chk({tag, "_mag"}, 32'(mag_s), 32'(x_mag));
        chk({tag, "_exp"}, 32'(exp_s), 32'(x_exp));
        chk({tag, "_sign"}, 32'(sign_s), 32'(x_sign));
        chk({tag, "_zero"}, 32'(zero), 32'(x_z));
        chk({tag, "_ovf"}, 32'(ovf), 32'(x_o));
        chk({tag, "_unf"}, 32'(unf), 32'(x_u));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_hold_mag"}, 32'(mag_s), 32'(x_mag));
    endtask

    initial begin
        int saw_done;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mag", 32'(mag_s), 32'd0);
        chk("rst_exp", 32'(exp_s), 32'd0);
        chk("rst_flags", {29'd0, zero, ovf, unf}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("carry", 1'b0, 24'h800000, 1'b0, 24'h800000, 8'd10, 1'b0, -1,
               24'h800000, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run_op("cancel", 1'b0, 24'h800000, 1'b0, 24'h7FFFFF, 8'd100, 1'b1, -1,
               24'h800000, 8'd77, 1'b0, 1'b0, 1'b0, 1'b0, 25);
        run_op("zero", 1'b1, 24'h400000, 1'b0, 24'h400000, 8'd40, 1'b0, -1,
               24'h000000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        run_op("ovf", 1'b0, 24'hC00000, 1'b0, 24'hC00000, 8'hFE, 1'b0, -1,
               24'hC00000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_op("unf", 1'b0, 24'h800001, 1'b0, 24'h800000, 8'd2, 1'b1, -1,
               24'h000004, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        run_op("neg_big_b", 1'b0, 24'h400000, 1'b0, 24'hC00000, 8'd50, 1'b1, -1,
               24'h800000, 8'd50, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        run_op("glitch", 1'b0, 24'h800000, 1'b0, 24'h7FFFFF, 8'd100, 1'b1, 6,
               24'h800000, 8'd77, 1'b0, 1'b0, 1'b0, 1'b0, 25);

        // Abort mid-NORM: outputs clear without a clock edge and no done follows.
        @(negedge clk);
        sign_a = 1'b0; mag_a = 24'h800000; sign_b = 1'b0; mag_b = 24'h7FFFFF;
        exp_in = 8'd100; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mag", 32'(mag_s), 32'd0);
        chk("abort_exp", 32'(exp_s), 32'd0);
        chk("abort_flags", {28'd0, sign_s, zero, ovf, unf}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        run_op("after_rst", 1'b0, 24'h800001, 1'b0, 24'h800000, 8'd2, 1'b1, -1,
               24'h000004, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
